// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states and the
// single-cycle result mux.
package alu_pkg;

   localparam logic [3:0] OpAnd  = 4'b0000;
   localparam logic [3:0] OpXor  = 4'b0001;
   localparam logic [3:0] OpSll  = 4'b0010;
   localparam logic [3:0] OpAdd  = 4'b0011;
   localparam logic [3:0] OpSub  = 4'b0100;
   localparam logic [3:0] OpMul  = 4'b0101;
   localparam logic [3:0] OpAddi = 4'b0110;
   localparam logic [3:0] OpSrai = 4'b0111;
   localparam logic [3:0] OpLw   = 4'b1000;
   localparam logic [3:0] OpSw   = 4'b1001;
   localparam logic [3:0] OpBeq  = 4'b1010;
   localparam logic [3:0] OpDiv  = 4'b1011;
   localparam logic [3:0] OpRem  = 4'b1100;
   localparam logic [3:0] OpSrl  = 4'b1101;
   localparam logic [3:0] OpOr   = 4'b1110;
   localparam logic [3:0] OpRsvd = 4'b1111;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMul  = 2'd1,
      StDiv  = 2'd2,
      StDone = 2'd3
   } state_e;

   localparam int unsigned MaxXlen = 64;

   // Operands arrive zero-extended to MaxXlen; xlen locates the sign bit for SRAI.
   // The caller truncates the result back to its own width.
   function automatic logic [MaxXlen-1:0] single_cycle_result(
      input logic [3:0]         op,
      input logic [MaxXlen-1:0] a,
      input logic [MaxXlen-1:0] b,
      input logic [5:0]         shamt,
      input int unsigned        xlen
   );
      logic [MaxXlen-1:0] mask;
      logic [MaxXlen-1:0] top_bit;
      logic [MaxXlen-1:0] a_sext;
      logic [MaxXlen-1:0] res;
      mask    = (xlen >= MaxXlen) ? '1 : ((64'd1 << xlen) - 64'd1);
      top_bit = mask ^ (mask >> 1);
      a_sext  = (|(a & top_bit)) ? (a | ~mask) : a;
      case (op)
         OpAnd:                      res = a & b;
         OpXor:                      res = a ^ b;
         OpOr:                       res = a | b;
         OpSll:                      res = a << shamt;
         OpSrl:                      res = a >> shamt;
         OpSrai:                     res = $unsigned($signed(a_sext) >>> shamt);
         OpAdd, OpAddi, OpLw, OpSw:  res = a + b;
         OpSub, OpBeq:               res = a - b;
         default:                    res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Restoring divider on unsigned magnitudes, one quotient bit per step.
module alu_div_iter #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            step_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] quo_o,
   output logic [XLEN-1:0] rem_o
);

   logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
   logic [XLEN-1:0] quo_step, rem_step;
   logic [XLEN:0]   shifted, trial;

   always_comb begin
      shifted = {rem_q, quo_q[XLEN-1]};
      trial   = shifted - {1'b0, dvs_q};
      if (trial[XLEN]) begin
         rem_step = shifted[XLEN-1:0];
         quo_step = {quo_q[XLEN-2:0], 1'b0};
      end else begin
         rem_step = trial[XLEN-1:0];
         quo_step = {quo_q[XLEN-2:0], 1'b1};
      end
   end

   always_comb begin
      quo_d = quo_q;
      rem_d = rem_q;
      dvs_d = dvs_q;
      if (start_i) begin
         quo_d = dividend_i;
         rem_d = '0;
         dvs_d = divisor_i;
      end else if (step_i) begin
         quo_d = quo_step;
         rem_d = rem_step;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
      end else begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
      end
   end

   // Values after the step in progress, so the last step can be latched directly.
   assign quo_o = quo_step;
   assign rem_o = rem_step;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish in one cycle; MUL/DIV/REM iterate XLEN cycles.
module alu_mc
   import alu_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned SHW  = $clog2(XLEN)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [3:0]      ALUCtrl_i,
   input  logic [XLEN-1:0] data1_i,
   input  logic [XLEN-1:0] data2_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] data_o,
   output logic            zero_o
);

   localparam int unsigned CntW = $clog2(XLEN) + 1;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            valid_q, valid_d, zero_q, zero_d;
   logic [XLEN-1:0] data_q, data_d, mcand_q, mcand_d, mplr_q, mplr_d, acc_q, acc_d;
   logic            sign_a_q, sign_a_d, sign_b_q, sign_b_d;
   logic            is_rem_q, is_rem_d, b_zero_q, b_zero_d;

   logic            accept, is_mul, is_div, div_start, div_step;
   logic [XLEN-1:0] a_mag, b_mag, div_quo, div_rem, quo_fix, rem_fix, div_res;
   logic [XLEN-1:0] single_res, acc_next;

   assign ready_o = !flush_i && (state_q == StIdle || (state_q == StDone && ready_i));
   assign accept  = valid_i && ready_o;
   assign is_mul  = (ALUCtrl_i == OpMul);
   assign is_div  = (ALUCtrl_i == OpDiv) || (ALUCtrl_i == OpRem);
   assign a_mag   = data1_i[XLEN-1] ? -data1_i : data1_i;
   assign b_mag   = data2_i[XLEN-1] ? -data2_i : data2_i;

   assign single_res = XLEN'(single_cycle_result(ALUCtrl_i, MaxXlen'(data1_i), MaxXlen'(data2_i),
                                                 6'(data2_i[SHW-1:0]), XLEN));

   assign acc_next = acc_q + (mplr_q[0] ? mcand_q : '0);

   // Divide-by-zero yields all-ones regardless of sign; remainder keeps the dividend.
   assign quo_fix = b_zero_q ? '1 : ((sign_a_q ^ sign_b_q) ? -div_quo : div_quo);
   assign rem_fix = sign_a_q ? -div_rem : div_rem;
   assign div_res = is_rem_q ? rem_fix : quo_fix;

   alu_div_iter #(
      .XLEN(XLEN)
   ) u_div (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (div_start),
      .step_i    (div_step),
      .dividend_i(a_mag),
      .divisor_i (b_mag),
      .quo_o     (div_quo),
      .rem_o     (div_rem)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      valid_d   = valid_q;
      zero_d    = zero_q;
      data_d    = data_q;
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      acc_d     = acc_q;
      sign_a_d  = sign_a_q;
      sign_b_d  = sign_b_q;
      is_rem_d  = is_rem_q;
      b_zero_d  = b_zero_q;
      div_start = 1'b0;
      div_step  = 1'b0;

      if (accept) begin
         valid_d = 1'b0;
         zero_d  = 1'b0;
         if (is_mul) begin
            state_d = StMul;
            cnt_d   = CntW'(XLEN);
            mcand_d = data1_i;
            mplr_d  = data2_i;
            acc_d   = '0;
         end else if (is_div) begin
            state_d   = StDiv;
            cnt_d     = CntW'(XLEN);
            div_start = 1'b1;
            sign_a_d  = data1_i[XLEN-1];
            sign_b_d  = data2_i[XLEN-1];
            is_rem_d  = (ALUCtrl_i == OpRem);
            b_zero_d  = (data2_i == '0);
         end else begin
            state_d = StDone;
            data_d  = single_res;
            zero_d  = (single_res == '0);
            valid_d = 1'b1;
         end
      end else begin
         unique case (state_q)
            StMul: begin
               cnt_d   = cnt_q - CntW'(1);
               acc_d   = acc_next;
               mcand_d = mcand_q << 1;
               mplr_d  = mplr_q >> 1;
               if (cnt_q == CntW'(1)) begin
                  state_d = StDone;
                  data_d  = acc_next;
                  zero_d  = (acc_next == '0);
                  valid_d = 1'b1;
               end
            end
            StDiv: begin
               cnt_d    = cnt_q - CntW'(1);
               div_step = 1'b1;
               if (cnt_q == CntW'(1)) begin
                  state_d = StDone;
                  data_d  = div_res;
                  zero_d  = (div_res == '0);
                  valid_d = 1'b1;
               end
            end
            StDone: begin
               if (ready_i) begin
                  state_d = StIdle;
                  valid_d = 1'b0;
                  zero_d  = 1'b0;
               end
            end
            default: ;
         endcase
      end

      // Flush drops any in-flight or pending result but leaves data_o as it was.
      if (flush_i) begin
         state_d = StIdle;
         cnt_d   = '0;
         valid_d = 1'b0;
         zero_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         zero_q   <= 1'b0;
         data_q   <= '0;
         mcand_q  <= '0;
         mplr_q   <= '0;
         acc_q    <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         is_rem_q <= 1'b0;
         b_zero_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         zero_q   <= zero_d;
         data_q   <= data_d;
         mcand_q  <= mcand_d;
         mplr_q   <= mplr_d;
         acc_q    <= acc_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         is_rem_q <= is_rem_d;
         b_zero_q <= b_zero_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign zero_o  = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: vector table through a scoreboard, plus handshake, flush,
// reset and XLEN=16 sequences.
module tb_alu_mc;

   localparam int unsigned XLEN = 32;

   localparam logic [3:0] OpAnd  = 4'b0000;
   localparam logic [3:0] OpXor  = 4'b0001;
   localparam logic [3:0] OpSll  = 4'b0010;
   localparam logic [3:0] OpAdd  = 4'b0011;
   localparam logic [3:0] OpSub  = 4'b0100;
   localparam logic [3:0] OpMul  = 4'b0101;
   localparam logic [3:0] OpAddi = 4'b0110;
   localparam logic [3:0] OpSrai = 4'b0111;
   localparam logic [3:0] OpLw   = 4'b1000;
   localparam logic [3:0] OpSw   = 4'b1001;
   localparam logic [3:0] OpBeq  = 4'b1010;
   localparam logic [3:0] OpDiv  = 4'b1011;
   localparam logic [3:0] OpRem  = 4'b1100;
   localparam logic [3:0] OpSrl  = 4'b1101;
   localparam logic [3:0] OpOr   = 4'b1110;
   localparam logic [3:0] OpRsvd = 4'b1111;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i, flush_i, valid_i, ready_i;
   logic [3:0]  alu_ctrl;
   logic [31:0] data1, data2;
   logic        ready_o, valid_o, zero_o;
   logic [31:0] data_o;

   logic        valid16_i;
   logic        flush16 = 1'b0;
   logic        rdy16 = 1'b1;
   logic [3:0]  ctrl16;
   logic [15:0] a16, b16;
   logic        ready16_o, valid16_o, zero16_o;
   logic [15:0] data16_o;

   alu_mc #(.XLEN(32)) dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
      .ALUCtrl_i(alu_ctrl), .data1_i(data1), .data2_i(data2), .valid_o(valid_o),
      .ready_i(ready_i), .data_o(data_o), .zero_o(zero_o)
   );

   alu_mc #(.XLEN(16)) dut16 (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush16), .valid_i(valid16_i), .ready_o(ready16_o),
      .ALUCtrl_i(ctrl16), .data1_i(a16), .data2_i(b16), .valid_o(valid16_o),
      .ready_i(rdy16), .data_o(data16_o), .zero_o(zero16_o)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] data;
      logic        zero;
      int          cyc;
      string       name;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
   } vec_t;
   vec_t vecs[$];

   function automatic bit is_multi(input logic [3:0] op);
      return (op == OpMul) || (op == OpDiv) || (op == OpRem);
   endfunction

   task automatic add_vec(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic z);
      vec_t v;
      v.name = name; v.op = op; v.a = a; v.b = b; v.res = res; v.z = z;
      vecs.push_back(v);
   endtask

   task automatic push_exp(input string name, input logic [31:0] d, input logic z, input int c);
      exp_t e;
      e.name = name; e.data = d; e.zero = z; e.cyc = c;
      sb.push_back(e);
   endtask

   // Result monitor: first_cyc marks when the current result first appeared.
   bit   fresh = 1'b1;
   int   first_cyc = 0;
   exp_t mon_e;
   always @(negedge clk) begin
      if (rst_i !== 1'b0 || valid_o !== 1'b1) begin
         fresh = 1'b1;
      end else begin
         if (fresh) begin
            first_cyc = cyc;
            fresh = 1'b0;
         end
         if (ready_i === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected valid_o", valid_o, 0);
            end else begin
               mon_e = sb.pop_front();
               chk({mon_e.name, " data"}, data_o, mon_e.data);
               chk({mon_e.name, " zero"}, zero_o, mon_e.zero);
               chk({mon_e.name, " latency"}, first_cyc, mon_e.cyc);
            end
            fresh = 1'b1;
         end
      end
   end

   // Called just after a posedge; returns just after the accepting posedge.
   task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic z,
                        input bit push, output int waited);
      bit ok = 1'b0;
      valid_i = 1'b1; alu_ctrl = op; data1 = a; data2 = b;
      waited = 0;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         ok = (ready_o === 1'b1);
         @(posedge clk);
         #1;
         if (!ok) waited++;
      end
      chk({name, " accepted"}, ok, 1);
      if (ok && push) push_exp(name, res, z, cyc + (is_multi(op) ? XLEN : 0));
      valid_i = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (sb.size() != 0 && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("scoreboard drained", sb.size(), 0);
   endtask

   task automatic run16(input string name, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] r);
      bit ok;
      bit found = 1'b0;
      int c;
      valid16_i = 1'b1; ctrl16 = op; a16 = a; b16 = b;
      @(negedge clk);
      ok = (ready16_o === 1'b1);
      @(posedge clk);
      #1;
      valid16_i = 1'b0;
      c = cyc;
      chk({name, " accepted"}, ok, 1);
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         found = (valid16_o === 1'b1);
      end
      chk({name, " latency"}, cyc - c, 16);
      chk({name, " data"}, data16_o, r);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  w;
      bit  prev_multi;
      int  bad;

      rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
      alu_ctrl = '0; data1 = '0; data2 = '0;
      valid16_i = 1'b0; ctrl16 = '0; a16 = '0; b16 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset valid_o", valid_o, 0);
      chk("reset data_o", data_o, 0);
      chk("reset zero_o", zero_o, 0);
      rst_i = 1'b0;
      @(negedge clk);
      chk("reset ready_o", ready_o, 1);
      @(posedge clk);
      #1;

      add_vec("ADD",      OpAdd,  32'd7,         32'hFFFF_FFFD, 32'd4,         1'b0);
      add_vec("SRAI",     OpSrai, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0);
      add_vec("SLL",      OpSll,  32'd1,         32'd35,        32'd8,         1'b0);
      add_vec("BEQ_eq",   OpBeq,  32'd5,         32'd5,         32'd0,         1'b1);
      add_vec("AND",      OpAnd,  32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 1'b0);
      add_vec("XOR",      OpXor,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0);
      add_vec("SUB",      OpSub,  32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0);
      add_vec("OR",       OpOr,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0);
      add_vec("SRL",      OpSrl,  32'h8000_0000, 32'd33,        32'h4000_0000, 1'b0);
      add_vec("ADDI",     OpAddi, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1);
      add_vec("LW",       OpLw,   32'h0000_1000, 32'h24,        32'h0000_1024, 1'b0);
      add_vec("SW",       OpSw,   32'h10,        32'hFFFF_FFF0, 32'd0,         1'b1);
      add_vec("RSVD",     OpRsvd, 32'h123,       32'h456,       32'd0,         1'b1);
      add_vec("BEQ_ne",   OpBeq,  32'd5,         32'd6,         32'hFFFF_FFFF, 1'b0);
      add_vec("MUL",      OpMul,  32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFD, 1'b0);
      add_vec("DIV",      OpDiv,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
      add_vec("REM",      OpRem,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0);
      add_vec("DIV_by0",  OpDiv,  32'd10,        32'd0,         32'hFFFF_FFFF, 1'b0);
      add_vec("REM_by0",  OpRem,  32'd10,        32'd0,         32'd10,        1'b0);
      add_vec("DIV_ovf",  OpDiv,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
      add_vec("REM_ovf",  OpRem,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1);
      add_vec("MUL2",     OpMul,  32'd12345,     32'd6789,      32'h04FE_D79D, 1'b0);
      add_vec("DIV_neg",  OpDiv,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
      add_vec("REM_neg",  OpRem,  32'd100,       32'hFFFF_FFF9, 32'd2,         1'b0);
      add_vec("REM_n0",   OpRem,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b0);

      prev_multi = 1'b0;
      foreach (vecs[i]) begin
         issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].z, 1'b1, w);
         chk({vecs[i].name, " ready wait"}, w, prev_multi ? XLEN : 0);
         prev_multi = is_multi(vecs[i].op);
      end
      drain();

      // Backpressure: result held, pending request taken in the cycle it is consumed.
      ready_i = 1'b0;
      issue("BP_ADD", OpAdd, 32'd2, 32'd3, 32'd5, 1'b0, 1'b1, w);
      valid_i = 1'b1; alu_ctrl = OpSub; data1 = 32'd9; data2 = 32'd9;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (valid_o !== 1'b1 || data_o !== 32'd5 || zero_o !== 1'b0 || ready_o !== 1'b0) bad++;
      end
      chk("backpressure hold", bad, 0);
      @(posedge clk);
      #1;
      ready_i = 1'b1;
      @(negedge clk);
      chk("backpressure release ready_o", ready_o, 1);
      @(posedge clk);
      #1;
      push_exp("BP_SUB", 32'd0, 1'b1, cyc);
      valid_i = 1'b0; data1 = 32'h55;
      drain();

      // Flush during a DIV with a simultaneous request.
      issue("FL_DIV", OpDiv, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, w);
      repeat (9) @(posedge clk);
      #1;
      flush_i = 1'b1; valid_i = 1'b1; alu_ctrl = OpAdd; data1 = 32'd5; data2 = 32'd5;
      @(negedge clk);
      chk("flush ready_o", ready_o, 0);
      @(posedge clk);
      #1;
      flush_i = 1'b0; valid_i = 1'b0;
      @(negedge clk);
      chk("flush valid_o", valid_o, 0);
      chk("flush idle ready_o", ready_o, 1);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (valid_o !== 1'b0) bad++;
      end
      chk("flushed DIV silent", bad, 0);
      @(posedge clk);
      #1;
      issue("FL_ADD", OpAdd, 32'd1, 32'd1, 32'd2, 1'b0, 1'b1, w);
      drain();

      // Reset mid-MUL clears the held result too.
      issue("RS_MUL", OpMul, 32'd7, 32'd9, 32'd63, 1'b0, 1'b0, w);
      repeat (10) @(posedge clk);
      #1;
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      chk("midreset valid_o", valid_o, 0);
      chk("midreset data_o", data_o, 0);
      chk("midreset zero_o", zero_o, 0);
      rst_i = 1'b0;
      @(negedge clk);
      chk("midreset ready_o", ready_o, 1);
      @(posedge clk);
      #1;
      issue("RS_ADD0", OpAdd, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, w);
      drain();

      run16("X16_MUL",     OpMul, 16'hFFFF, 16'd3,    16'hFFFD);
      run16("X16_DIV",     OpDiv, 16'hFFF9, 16'd2,    16'hFFFD);
      run16("X16_REM",     OpRem, 16'hFFF9, 16'd2,    16'hFFFF);
      run16("X16_DIV_ovf", OpDiv, 16'h8000, 16'hFFFF, 16'h8000);
      run16("X16_DIV_by0", OpDiv, 16'd10,   16'd0,    16'hFFFF);
      run16("X16_REM_by0", OpRem, 16'd10,   16'd0,    16'd10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
